// File: rtl/target_codeblock_lp.sv
// Loop-peeled target program: x=secret; k=1; out=x%k; then while (k<ITER) {x=x+x; k++; out=x%k}.
// One program statement per non-stuttered clock; stutter_in freezes all program state.
module target_codeblock_lp #(
    parameter int SECRET_W = 2,
    parameter int X_W      = 4,
    parameter int OUT_W    = 2,
    parameter int ITER     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stutter_in,
    input  logic [SECRET_W-1:0] secret_in,
    output logic [OUT_W-1:0]    public_out,
    output logic                stutter,
    output logic                done
);

    typedef enum logic [3:0] {
        S_ENTRY    = 4'd0,
        S_INIT_X   = 4'd1,
        S_INIT_K   = 4'd2,
        S_PEEL_X   = 4'd3,
        S_PEEL_K   = 4'd4,
        S_PEEL_OUT = 4'd5,
        S_COND     = 4'd6,
        S_BODY_X   = 4'd7,
        S_BODY_K   = 4'd8,
        S_BODY_OUT = 4'd9,
        S_HALT     = 4'd10
    } step_t;

    localparam logic [OUT_W:0] K_BOUND = (OUT_W + 1)'(ITER);

    step_t            r_step;
    logic [X_W-1:0]   r_x;
    logic [OUT_W-1:0] r_k;
    logic [OUT_W-1:0] r_out;
    logic             r_stutter;
    logic             r_done;

    step_t            w_step_nxt;
    logic [X_W-1:0]   w_x_nxt;
    logic [OUT_W-1:0] w_k_nxt;
    logic [OUT_W-1:0] w_out_nxt;
    logic             w_done_nxt;
    logic [X_W-1:0]   w_k_ext;
    logic [X_W-1:0]   w_rem;

    // k is always >= 1 in the two output states, so the divisor is never zero there
    assign w_k_ext = X_W'(r_k);
    assign w_rem   = r_x % w_k_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step    <= S_ENTRY;
            r_x       <= '0;
            r_k       <= '0;
            r_out     <= '0;
            r_stutter <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_step    <= w_step_nxt;
            r_x       <= w_x_nxt;
            r_k       <= w_k_nxt;
            r_out     <= w_out_nxt;
            r_stutter <= stutter_in;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_step_nxt = r_step;
        w_x_nxt    = r_x;
        w_k_nxt    = r_k;
        w_out_nxt  = r_out;
        w_done_nxt = r_done;
        if (!stutter_in) begin
            case (r_step)
                S_ENTRY:    w_step_nxt = S_INIT_X;
                S_INIT_X: begin
                    w_x_nxt    = '0;
                    w_step_nxt = S_INIT_K;
                end
                S_INIT_K: begin
                    w_k_nxt    = '0;
                    w_step_nxt = S_PEEL_X;
                end
                S_PEEL_X: begin
                    w_x_nxt    = X_W'(secret_in);
                    w_step_nxt = S_PEEL_K;
                end
                S_PEEL_K: begin
                    w_k_nxt    = r_k + OUT_W'(1);
                    w_step_nxt = S_PEEL_OUT;
                end
                S_PEEL_OUT: begin
                    w_out_nxt  = OUT_W'(w_rem);
                    w_step_nxt = S_COND;
                end
                S_COND: begin
                    if ({1'b0, r_k} < K_BOUND) begin
                        w_step_nxt = S_BODY_X;
                    end else begin
                        // done rises on the exit edge so it is already high while step=HALT
                        w_step_nxt = S_HALT;
                        w_done_nxt = 1'b1;
                    end
                end
                S_BODY_X: begin
                    w_x_nxt    = r_x + r_x;
                    w_step_nxt = S_BODY_K;
                end
                S_BODY_K: begin
                    w_k_nxt    = r_k + OUT_W'(1);
                    w_step_nxt = S_BODY_OUT;
                end
                S_BODY_OUT: begin
                    w_out_nxt  = OUT_W'(w_rem);
                    w_step_nxt = S_COND;
                end
                default:    w_done_nxt = 1'b1;
            endcase
        end
    end

    assign public_out = r_out;
    assign stutter    = r_stutter;
    assign done       = r_done;

endmodule

// File: doc/target_codeblock_lp.md
Name: target_codeblock_lp

Overview:
- Loop-peeled counterpart ("target" program) of the source-codeblock model, for the lp compiler-optimization case study.
- Computes: x=0; k=0; x=secret; k=k+1; out=x%k; then while (k<3) { x=x+x; k=k+1; out=x%k }.
- Executes as a stutterable step machine, one program statement per non-stuttering clock.
- Its stutter/public_out trace is checked against the source model for asynchronous hyperproperties (observational equivalence, noninterference).

Parameters:
SECRET_W, 2, width of secret_in
X_W, 4, width of accumulator x; must hold secret max * 2^(ITER-1)
OUT_W, 2, width of public_out and loop counter k
ITER, 3, total loop iterations including the peeled one (k bound)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
stutter_in  input  1  1 = hold all program state this cycle
secret_in  input  SECRET_W  secret value, sampled only in state PEEL_X
public_out  output  OUT_W  public observable, registered
stutter  output  1  registered copy of stutter_in
done  output  1  registered, 1 while in state HALT

Behaviour:
- Reset (async, rst=1): step=0, x=0, k=0, public_out=0, stutter=0, done=0; effective immediately; holds while rst=1; resume at step 0 on the first clk edge after deassertion.
- Every edge: stutter <= stutter_in. If stutter_in=1: step, x, k, public_out, done unchanged.
- If stutter_in=0, step transitions (step register 4 bits):
  0 ENTRY: no-op -> 1
  1 INIT_X: x<=0 -> 2
  2 INIT_K: k<=0 -> 3
  3 PEEL_X: x<=zero-extended secret_in -> 4
  4 PEEL_K: k<=k+1 -> 5
  5 PEEL_OUT: public_out<=x%k -> 6
  6 COND: k<ITER ? 7 : 10
  7 BODY_X: x<=x+x (mod 2^X_W) -> 8
  8 BODY_K: k<=k+1 (mod 2^OUT_W) -> 9
  9 BODY_OUT: public_out<=x%k -> 6
  10 HALT: done<=1; all else held; terminal until reset
  11-15: illegal; treat as HALT (done<=1, no state change).
- % is unsigned. k is never 0 at PEEL_OUT/BODY_OUT, so no divide-by-zero path exists. Result is truncated to OUT_W; the remainder is always < k, so no information is lost.
- The peeled iteration has no k==0 test. secret_in is read in exactly one state; its value at all other cycles is ignored.
- Latency with stutter_in held 0 from reset release, ITER=3:
  - public_out updates on edges 6, 10, 14.
  - COND exits on edge 15; done=1 after edge 15.
- Each stuttered cycle delays all later events by exactly one cycle.
- Reset asserted mid-operation (any step, including HALT) aborts and clears everything; no partial state survives.

Test Plan:
1. secret_in=1, stutter_in=0, release rst -> public_out 0 after edge 6, 0 after edge 10, 1 after edge 14; done=1 after edge 15; x=4, k=3 at HALT.
2. secret_in=2 -> public_out 0, 0, 2 at edges 6/10/14; final x=8. secret_in=3 -> public_out 0, 0, 0; final x=12. secret_in=0 -> public_out all 0.
3. secret_in=1, stutter_in=1 on cycles 3-5 after reset -> stutter output mirrors stutter_in delayed 1 cycle; public_out events shift to edges 9/13/17; done after edge 18.
4. Change secret_in every cycle, with value 3 held only on the edge where step=3 -> results identical to a constant secret_in=3.
5. Assert rst asynchronously (between clk edges) while step=8 -> all outputs 0 at once; after release, the full sequence of test 1 repeats.
6. Hold in HALT for 20 cycles with toggling stutter_in and secret_in -> public_out, done stay constant; stutter still tracks stutter_in.
